instr_sequencer: RTL and testbench

Fetch/decode/execute controller for the 8-bit instruction memory (combinational read, 8-bit address, 8-bit instruction).
- Owns the program counter and drives the memory address.
- Latches each instruction, decodes the 2-bit opcode and issues a one-cycle register-write strobe to the datapath.
- Handles jumps, stop and out-of-range faults.
- Sits between the instruction memory and the register file/display datapath.

---
 rtl/instr_sequencer_pkg.sv | 9 +
 rtl/instr_decoder.sv | 23 ++
 rtl/instr_sequencer.sv | 120 ++++++++++++
 tb/tb_instr_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: opcodes, operands and FSM states shared by the sequencer slice
package instr_sequencer_pkg;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_JUMP  = 2'b10;
  localparam logic [1:0] OP_SYS   = 2'b11;
  localparam logic [5:0] STOP_OPERAND = 6'b000011;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_e;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational split of an instruction word into action flags and fields
module instr_decoder
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [7:0]        ir_i,
  output logic              is_write_o,
  output logic              is_jump_o,
  output logic              is_stop_o,
  output logic              is_reserved_o,
  output logic [1:0]        dst_o,
  output logic [1:0]        src_o,
  output logic [ADDR_W-1:0] target_o
);
  assign is_write_o    = ir_i[7:6] == OP_WRITE;
  assign is_jump_o     = ir_i[7:6] == OP_JUMP;
  assign is_stop_o     = ir_i[7:6] == OP_SYS && ir_i[5:0] == STOP_OPERAND;
  assign is_reserved_o = ir_i[7:6] == OP_SYS && ir_i[5:0] != STOP_OPERAND;
  assign dst_o         = ir_i[5:4];
  assign src_o         = ir_i[3:2];
  assign target_o      = ADDR_W'(ir_i[5:0]);
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller owning the PC, write strobe and retire counter
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 32,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              pause,
  input  logic [7:0]        instruction,
  output logic [ADDR_W-1:0] address,
  output logic              wr_en,
  output logic [1:0]        wr_dst,
  output logic [1:0]        wr_src,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [7:0] ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d, retired_inc;
  logic [1:0] dst_q, dst_d, src_q, src_d;
  logic wr_en_q, wr_en_d, fault_q, fault_d, busy_q, halted_q;
  logic is_write, is_jump, is_stop, is_reserved;
  logic [1:0] dec_dst, dec_src;
  logic [ADDR_W-1:0] target;
  instr_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .ir_i(ir_q), .is_write_o(is_write), .is_jump_o(is_jump), .is_stop_o(is_stop),
    .is_reserved_o(is_reserved), .dst_o(dec_dst), .src_o(dec_src), .target_o(target)
  );
  assign retired_inc = &retired_q ? retired_q : retired_q + CNT_W'(1);
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    dst_d     = dst_q;
    src_d     = src_q;
    wr_en_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d   = FETCH;
        address_d = '0;
        retired_d = '0;
        fault_d   = 1'b0;
      end
      FETCH: if (!pause) begin
        if ({1'b0, address_q} >= DEPTH) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          ir_d    = instruction;
          state_d = DECODE;
        end
      end
      // strobe and fields are registered here so they are clean for the whole EXEC cycle
      DECODE: begin
        state_d = EXEC;
        wr_en_d = is_write;
        dst_d   = dec_dst;
        src_d   = dec_src;
      end
      EXEC: begin
        state_d = FETCH;
        if (is_stop) state_d = HALT;
        else if (is_reserved) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (is_jump) begin
          address_d = target;
          retired_d = retired_inc;
        end else begin
          address_d = address_q + ADDR_W'(1);
          retired_d = is_write ? retired_inc : retired_q;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      address_q <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      dst_q     <= '0;
      src_q     <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= state_d == FETCH || state_d == DECODE || state_d == EXEC;
      halted_q  <= state_d == HALT;
    end
  end
  assign address = address_q;
  assign wr_en   = wr_en_q;
  assign wr_dst  = dst_q;
  assign wr_src  = src_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign fault   = fault_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: ISA-level timing model of the sequencer compared every cycle, plus literal pins
module tb_instr_sequencer;
  logic clk = 1'b0, clear = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] instruction, address, retired;
  logic wr_en, busy, halted, fault;
  logic [1:0] wr_dst, wr_src;
  logic [7:0] mem [256];
  int n_cmp = 0, n_fail = 0, cyc = 0;
  int p_from, p_to, n_wr, first_wr, last_wr, first_halt;
  typedef struct {
    logic busy, halted, fault, wr;
    logic [1:0] dst, src;
    logic [7:0] addr, ret;
  } exp_t;
  exp_t eq[$];
  always #5 clk = ~clk;
  assign instruction = mem[address];
  instr_sequencer dut (
    .clk(clk), .clear(clear), .start(start), .pause(pause), .instruction(instruction),
    .address(address), .wr_en(wr_en), .wr_dst(wr_dst), .wr_src(wr_src), .busy(busy),
    .halted(halted), .fault(fault), .retired(retired)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask
  function automatic int sat(input int r);
    return r >= 255 ? 255 : r + 1;
  endfunction
  // Interprets the program in mem: each instruction costs fetch(+pause)/decode/exec cycles
  task automatic build(input int pidx, input int plen, input int maxins);
    int pc = 0, r = 0;
    exp_t e;
    logic [7:0] ins;
    eq.delete();
    p_from = 0;
    p_to = -1;
    for (int idx = 0; idx < maxins; idx++) begin
      e.busy = 1; e.halted = 0; e.fault = 0; e.wr = 0; e.dst = 0; e.src = 0;
      e.addr = pc[7:0]; e.ret = r[7:0];
      if (pc >= 32) begin
        eq.push_back(e);
        e.busy = 0; e.halted = 1; e.fault = 1;
        repeat (4) eq.push_back(e);
        break;
      end
      if (idx == pidx) begin
        p_from = eq.size() + 1;
        p_to = p_from + plen - 1;
      end
      repeat (1 + (idx == pidx ? plen : 0)) eq.push_back(e);
      eq.push_back(e);
      ins = mem[pc];
      e.wr = ins[7:6] == 2'b01; e.dst = ins[5:4]; e.src = ins[3:2];
      eq.push_back(e);
      if (ins[7:6] == 2'b11) begin
        e.wr = 0; e.busy = 0; e.halted = 1; e.fault = ins[5:0] != 6'd3;
        repeat (4) eq.push_back(e);
        break;
      end
      if (ins[7:6] == 2'b10) begin
        pc = int'(ins[5:0]);
        r = sat(r);
      end else begin
        pc = (pc + 1) % 256;
        if (ins[7:6] == 2'b01) r = sat(r);
      end
    end
  endtask
  task automatic run();
    exp_t e;
    n_wr = 0; first_wr = 0; last_wr = 0; first_halt = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= eq.size(); c++) begin
      cyc = c;
      pause = c >= p_from && c <= p_to;
      @(negedge clk);
      e = eq[c-1];
      chk("address", address, e.addr);
      chk("busy", busy, e.busy);
      chk("halted", halted, e.halted);
      chk("fault", fault, e.fault);
      chk("retired", retired, e.ret);
      chk("wr_en", wr_en, e.wr);
      if (e.wr) begin
        chk("wr_dst", wr_dst, e.dst);
        chk("wr_src", wr_src, e.src);
      end
      if (wr_en) begin
        n_wr++;
        if (first_wr == 0) first_wr = c;
        last_wr = c;
      end
      if (halted && first_halt == 0) first_halt = c;
      @(posedge clk);
      #1;
    end
    pause = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk) clear = 1'b0;
    @(negedge clk);
    cyc = 0;
    chk("rst_address", address, 0);
    chk("rst_flags", {wr_en, busy, halted, fault}, 0);
    chk("rst_fields", {wr_dst, wr_src}, 0);
    chk("rst_retired", retired, 0);
    clear = 1'b1;
  endtask
  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask
  task automatic load_full();
    logic [7:0] pat [4];
    pat = '{8'h45, 8'h59, 8'h6D, 8'h71};
    fill(8'h00);
    for (int i = 0; i < 28; i++) mem[i] = pat[i%4];
    mem[28] = 8'hC3;
  endtask
  initial begin
    fill(8'h00);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_address", address, 0);
      chk("idle_flags", {wr_en, busy, halted}, 0);
    end
    load_full();
    build(-1, 0, 1000);
    run();
    chk("full_nwr", n_wr, 28);
    chk("full_first_wr", first_wr, 3);
    chk("full_last_wr", last_wr, 84);
    chk("full_first_halt", first_halt, 88);
    chk("full_address", address, 28);
    chk("full_retired", retired, 28);
    chk("full_fault", fault, 0);
    @(negedge clk) start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("halt_ignores_start", {halted, busy, address}, {1'b1, 1'b0, 8'd28});
    do_reset();
    fill(8'h00);
    mem[0] = 8'h85; mem[5] = 8'h45; mem[6] = 8'hC3;
    build(1, 4, 1000);
    run();
    chk("jump_pause_window", p_from, 4);
    chk("jump_nwr", n_wr, 1);
    chk("jump_first_wr", first_wr, 10);
    chk("jump_first_halt", first_halt, 14);
    chk("jump_retired", retired, 2);
    chk("jump_address", address, 6);
    do_reset();
    fill(8'h00);
    mem[0] = 8'hC0;
    build(-1, 0, 1000);
    run();
    chk("rsvd_first_halt", first_halt, 4);
    chk("rsvd_fault", fault, 1);
    do_reset();
    fill(8'h00);
    build(-1, 0, 1000);
    run();
    chk("oob_first_halt", first_halt, 98);
    chk("oob_address", address, 32);
    chk("oob_retired", retired, 0);
    chk("oob_fault", fault, 1);
    do_reset();
    fill(8'h00);
    mem[0] = 8'h45; mem[1] = 8'h80;
    build(-1, 0, 300);
    run();
    chk("sat_retired", retired, 255);
    do_reset();
    load_full();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    cyc = 9;
    chk("mid_wr_before", wr_en, 1);
    chk("mid_addr_before", address, 2);
    #1 clear = 1'b0;
    #1;
    chk("mid_wr_async", wr_en, 0);
    chk("mid_outputs_async", {address, retired, busy, halted, fault}, 0);
    @(negedge clk) clear = 1'b1;
    build(-1, 0, 1000);
    run();
    chk("rerun_retired", retired, 28);
    chk("rerun_first_halt", first_halt, 88);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
